// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: key code and buttons in, entry buffer and status pulses out.
interface keypad_entry_ctrl_if;
  logic [3:0] key;
  logic       time_button;
  logic       alarm_button;
  logic [3:0] key_ms_hr;
  logic [3:0] key_ls_hr;
  logic [3:0] key_ms_min;
  logic [3:0] key_ls_min;
  logic [2:0] digit_count;
  logic       key_strobe;
  logic       load_time;
  logic       load_alarm;
  logic       entry_error;
  logic       entry_timeout;

  modport master (
    output key, time_button, alarm_button,
    input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, digit_count,
           key_strobe, load_time, load_alarm, entry_error, entry_timeout
  );
  modport slave (
    input  key, time_button, alarm_button,
    output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, digit_count,
           key_strobe, load_time, load_alarm, entry_error, entry_timeout
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Debounced 4-digit keypad entry with time/alarm load, error and idle timeout.
// Optional macro KEY_RANGE_CHECK_EN: reject loads that are not a plausible HH:MM.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE       = 3,
  parameter int TIMEOUT_CYCLES = 2560
) (
  input logic           clk,
  input logic           rst,
  keypad_entry_ctrl_if.slave kif
);
  localparam int DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int IW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DEB, WAIT_REL} state_t;

  state_t          state, state_n;
  logic [3:0]      cand, cand_n;
  logic [DW-1:0]   deb_cnt, deb_n;
  logic            accept;
  logic            is_digit;

  logic [3:0][3:0] dig, dig_n;
  logic [2:0]      cnt, cnt_n;
  logic [IW-1:0]   idle, idle_n;
  logic [1:0]      btn_q;
  logic            clr_pend, clr_n;
  logic            carry_vld, carry_vld_n;
  logic [3:0]      carry_dig, carry_dig_n;
  logic            strobe_n, lt_n, la_n, err_n, to_n;
  logic            t_edge, a_edge, req, range_ok, load_ok;

  assign is_digit = (kif.key <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= '0;
      deb_cnt <= '0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      deb_cnt <= deb_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    deb_n   = deb_cnt;
    accept  = 1'b0;
    case (state)
      IDLE: if (is_digit) begin
        cand_n = kif.key;
        if (DEBOUNCE <= 1) begin
          accept  = 1'b1;
          deb_n   = '0;
          state_n = WAIT_REL;
        end else begin
          deb_n   = DW'(1);
          state_n = DEB;
        end
      end
      DEB: if (kif.key == cand) begin
        if (deb_cnt + DW'(1) >= DW'(DEBOUNCE)) begin
          accept  = 1'b1;
          deb_n   = '0;
          state_n = WAIT_REL;
        end else begin
          deb_n = deb_cnt + DW'(1);
        end
      end else begin
        deb_n   = '0;
        state_n = IDLE;
      end
      WAIT_REL: if (!is_digit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign t_edge = kif.time_button  & ~btn_q[0];
  assign a_edge = kif.alarm_button & ~btn_q[1];
  assign req    = t_edge | a_edge;

`ifdef KEY_RANGE_CHECK_EN
  assign range_ok = (dig[3] <= 4'd2) && ((dig[3] != 4'd2) || (dig[2] <= 4'd3)) &&
                    (dig[1] <= 4'd5);
`else
  assign range_ok = 1'b1;
`endif

  // the buffer is about to clear while clr_pend is set, so it never counts as full
  assign load_ok = req && (cnt == 3'd4) && !clr_pend && range_ok;

  always_comb begin
    dig_n       = dig;
    cnt_n       = cnt;
    idle_n      = idle;
    clr_n       = 1'b0;
    carry_vld_n = carry_vld;
    carry_dig_n = carry_dig;
    strobe_n    = 1'b0;
    lt_n        = 1'b0;
    la_n        = 1'b0;
    err_n       = 1'b0;
    to_n        = 1'b0;
    if (clr_pend) begin
      dig_n       = '0;
      cnt_n       = 3'd0;
      idle_n      = '0;
      carry_vld_n = 1'b0;
      if (carry_vld) begin
        dig_n[0] = carry_dig;
        cnt_n    = 3'd1;
        strobe_n = 1'b1;
      end
      if (req) err_n = 1'b1;
    end else if (load_ok) begin
      // a digit accepted on the load edge is parked and starts the next entry
      lt_n        = t_edge;
      la_n        = ~t_edge;
      clr_n       = 1'b1;
      carry_vld_n = accept;
      carry_dig_n = kif.key;
    end else if (req) begin
      err_n = 1'b1;
    end
    if (accept && !load_ok) begin
      dig_n    = {dig_n[2:0], kif.key};
      cnt_n    = (cnt_n == 3'd4) ? 3'd4 : cnt_n + 3'd1;
      strobe_n = 1'b1;
      idle_n   = '0;
    end else if (!clr_pend && !load_ok && (cnt != 3'd0) && (state == IDLE)) begin
      if (idle == IW'(TIMEOUT_CYCLES - 1)) begin
        dig_n  = '0;
        cnt_n  = 3'd0;
        idle_n = '0;
        to_n   = 1'b1;
      end else begin
        idle_n = idle + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig               <= '0;
      cnt               <= '0;
      idle              <= '0;
      btn_q             <= '0;
      clr_pend          <= 1'b0;
      carry_vld         <= 1'b0;
      carry_dig         <= '0;
      kif.key_strobe    <= 1'b0;
      kif.load_time     <= 1'b0;
      kif.load_alarm    <= 1'b0;
      kif.entry_error   <= 1'b0;
      kif.entry_timeout <= 1'b0;
    end else begin
      dig               <= dig_n;
      cnt               <= cnt_n;
      idle              <= idle_n;
      btn_q             <= {kif.alarm_button, kif.time_button};
      clr_pend          <= clr_n;
      carry_vld         <= carry_vld_n;
      carry_dig         <= carry_dig_n;
      kif.key_strobe    <= strobe_n;
      kif.load_time     <= lt_n;
      kif.load_alarm    <= la_n;
      kif.entry_error   <= err_n;
      kif.entry_timeout <= to_n;
    end
  end

  assign kif.key_ms_hr   = dig[3];
  assign kif.key_ls_hr   = dig[2];
  assign kif.key_ms_min  = dig[1];
  assign kif.key_ls_min  = dig[0];
  assign kif.digit_count = cnt;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with default parameters.
module tb_keypad_entry_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_strobe = 0, n_lt = 0, n_la = 0, n_err = 0, n_to = 0;

  keypad_entry_ctrl_if kif();

  keypad_entry_ctrl dut (.clk(clk), .rst(rst), .kif(kif));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kif.key_strobe)    n_strobe++;
    if (kif.load_time)     n_lt++;
    if (kif.load_alarm)    n_la++;
    if (kif.entry_error)   n_err++;
    if (kif.entry_timeout) n_to++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    kif.key = d;
    step(hold);
    kif.key = 4'd10;
    step(1);
  endtask

  function automatic logic [15:0] digits();
    return {kif.key_ms_hr, kif.key_ls_hr, kif.key_ms_min, kif.key_ls_min};
  endfunction

  initial begin
    int s0, to_k;
    rst = 1'b1;
    kif.key = 4'd10;
    kif.time_button = 1'b0;
    kif.alarm_button = 1'b0;
    step(2);
    chk("rst_digits", 32'(digits()), 32'h0);
    chk("rst_count", 32'(kif.digit_count), 0);
    chk("rst_pulses", 32'({kif.key_strobe, kif.load_time, kif.load_alarm,
                           kif.entry_error, kif.entry_timeout}), 0);
    rst = 1'b0;
    step(2);

    // two-cycle hold is a bounce, not a digit
    press(4'd5, 2);
    step(2);
    chk("short_strobe", 32'(n_strobe), 0);
    chk("short_count", 32'(kif.digit_count), 0);

    press(4'd7, 20);
    chk("hold_strobe", 32'(n_strobe), 1);
    chk("hold_count", 32'(kif.digit_count), 1);
    chk("hold_digit", 32'(kif.key_ls_min), 7);

    // reset during a debounce drops the partial digit and the buffer
    kif.key = 4'd3;
    step(2);
    rst = 1'b1;
    #1;
    chk("rst_mid_count", 32'(kif.digit_count), 0);
    kif.key = 4'd10;
    step(1);
    rst = 1'b0;
    step(3);
    chk("rst_mid_strobe", 32'(n_strobe), 1);
    chk("rst_mid_digits", 32'(digits()), 0);

    press(4'd1, 3); press(4'd1, 3); press(4'd2, 3); press(4'd3, 3);
    chk("e1123_strobes", 32'(n_strobe), 5);
    chk("e1123_count", 32'(kif.digit_count), 4);
    chk("e1123_digits", 32'(digits()), 32'h1123);
    kif.time_button = 1'b1;
    step(1);
    chk("lt_pulse", 32'(kif.load_time), 1);
    chk("lt_digits", 32'(digits()), 32'h1123);
    step(1);
    chk("lt_off", 32'(kif.load_time), 0);
    chk("lt_clr_count", 32'(kif.digit_count), 0);
    chk("lt_clr_digits", 32'(digits()), 0);
    step(4);
    kif.time_button = 1'b0;
    step(1);
    chk("lt_once", 32'(n_lt), 1);

    press(4'd1, 3); press(4'd1, 3); press(4'd3, 3);
    kif.alarm_button = 1'b1;
    step(1);
    chk("short_err", 32'(kif.entry_error), 1);
    chk("short_no_la", 32'(kif.load_alarm), 0);
    kif.alarm_button = 1'b0;
    step(1);
    chk("short_keep", 32'(digits()), 32'h0113);
    chk("short_keep_cnt", 32'(kif.digit_count), 3);
    press(4'd0, 3);
    kif.alarm_button = 1'b1;
    step(1);
    chk("la_pulse", 32'(kif.load_alarm), 1);
    chk("la_digits", 32'(digits()), 32'h1130);
    kif.alarm_button = 1'b0;
    step(1);
    chk("la_clr", 32'(kif.digit_count), 0);
    chk("la_once", 32'(n_la), 1);

    // fifth digit pushes out the oldest
    press(4'd1, 3); press(4'd2, 3); press(4'd3, 3); press(4'd4, 3); press(4'd5, 3);
    chk("shift_digits", 32'(digits()), 32'h2345);
    chk("shift_count", 32'(kif.digit_count), 4);

    kif.time_button = 1'b1;
    kif.alarm_button = 1'b1;
    step(1);
    chk("both_lt", 32'(kif.load_time), 1);
    chk("both_la", 32'(kif.load_alarm), 0);
    kif.time_button = 1'b0;
    kif.alarm_button = 1'b0;
    step(2);
    chk("both_la_cnt", 32'(n_la), 1);
    chk("both_clr", 32'(kif.digit_count), 0);

    // button edge on the accepting edge: load old buffer, digit starts new entry
    press(4'd2, 3); press(4'd3, 3); press(4'd5, 3); press(4'd9, 3);
    s0 = n_strobe;
    kif.key = 4'd5;
    step(2);
    kif.time_button = 1'b1;
    step(1);
    chk("race_lt", 32'(kif.load_time), 1);
    chk("race_digits", 32'(digits()), 32'h2359);
    step(1);
    chk("race_count", 32'(kif.digit_count), 1);
    chk("race_new", 32'(digits()), 32'h0005);
    chk("race_strobe", 32'(kif.key_strobe), 1);
    kif.time_button = 1'b0;
    kif.key = 4'd10;
    step(2);
    chk("race_strobes", 32'(n_strobe - s0), 1);

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    press(4'd2, 3); press(4'd5, 3); press(4'd0, 3); press(4'd0, 3);
    s0 = n_lt;
    kif.time_button = 1'b1;
    step(1);
`ifdef KEY_RANGE_CHECK_EN
    chk("range_err", 32'(kif.entry_error), 1);
    chk("range_no_lt", 32'(kif.load_time), 0);
    kif.time_button = 1'b0;
    step(2);
    chk("range_keep", 32'(digits()), 32'h2500);
`else
    chk("range_lt", 32'(kif.load_time), 1);
    chk("range_no_err", 32'(kif.entry_error), 0);
    kif.time_button = 1'b0;
    step(2);
    chk("range_clr", 32'(kif.digit_count), 0);
`endif

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    press(4'd1, 3); press(4'd2, 3);
    chk("to_pre_count", 32'(kif.digit_count), 2);
    to_k = 0;
    for (int i = 1; i <= 3000 && to_k == 0; i++) begin
      step(1);
      if (kif.entry_timeout) to_k = i;
    end
    chk("to_latency", 32'(to_k), 2560);
    chk("to_digits", 32'(digits()), 0);
    chk("to_count", 32'(kif.digit_count), 0);
    step(2);
    chk("to_once", 32'(n_to), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive cycles a digit code must be stable to be accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 2560: idle cycles after the last accepted digit before a partial entry is discarded.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 key  input  4  keypad code; 0-9 digit, 10 NOKEY, 11-15 treated as NOKEY.
REQ-006 time_button  input  1  request to load the entered digits as current time.
REQ-007 alarm_button  input  1  request to load the entered digits as alarm time.
REQ-008 key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  output  4 each  entry buffer digits.
REQ-009 digit_count  output  3  digits entered, 0-4.
REQ-010 key_strobe  output  1  one-cycle pulse per accepted digit.
REQ-011 load_time, load_alarm  output  1 each  one-cycle load pulses; buffer valid in the same cycle.
REQ-012 entry_error, entry_timeout  output  1 each  one-cycle status pulses.

Function
REQ-013 FSM states: IDLE, DEB, WAIT_REL.
REQ-014 IDLE: digit on key -> latch candidate, debounce count = 1, go DEB; NOKEY -> stay.
REQ-015 DEB: key == candidate -> count+1; count reaches DEBOUNCE -> accept, go WAIT_REL; key != candidate -> IDLE, no accept.
REQ-016 With DEBOUNCE=3, a digit held for exactly 3 sampled cycles is accepted; one held for 2 is not.
REQ-017 WAIT_REL: NOKEY -> IDLE; any other code -> stay. No auto-repeat while held.
REQ-018 Accept: shift left (ms_hr<-ls_hr<-ms_min<-ls_min<-digit), key_strobe=1 in the same cycle as the register update, digit_count+1 saturating at 4.
REQ-019 Fifth and later digits shift in, discard the oldest, digit_count stays 4.
REQ-020 Buttons are rising-edge detected internally; a held button yields one request.
REQ-021 Button edge with digit_count==4 (and valid per REQ-029) -> load pulse for one cycle, then buffer and digit_count clear to 0 on the next edge.
REQ-022 Button edge with digit_count<4 -> entry_error pulse, no load, buffer retained.
REQ-023 Simultaneous time and alarm edges -> load_time only, alarm request dropped.
REQ-024 Button edge in the same cycle as a digit accept -> load uses the pre-shift buffer; the accepted digit becomes digit 1 of the new entry (digit_count=1).
REQ-025 Idle counter runs while 0<digit_count and the FSM is IDLE; it resets on every accept. Reaching TIMEOUT_CYCLES -> buffer and count clear, entry_timeout pulse.
REQ-026 Loads have no latency beyond one cycle from the sampled button edge.

Reset
REQ-027 Reset asserted: FSM -> IDLE; all digits, digit_count, debounce and idle counters, and button edge history = 0; all pulse outputs = 0.
REQ-028 Reset mid-debounce or mid-entry discards the partial digit and the buffer; no pulse is emitted.

Configuration
REQ-029 Macro KEY_RANGE_CHECK_EN defined: a load requires ms_hr<=2, ls_hr<=3 when ms_hr==2, and ms_min<=5. Otherwise entry_error pulses and the buffer is retained. Undefined: any 4 digits load.

Verification
REQ-030 Keys 1,1,2,3, each held 3 cycles with 1 NOKEY cycle between, then time_button -> digits 1,1,2,3; load_time pulses once; count returns to 0.
REQ-031 Key 5 held 2 cycles then NOKEY -> no key_strobe; digit_count stays 0.
REQ-032 Key 7 held 20 cycles -> exactly one key_strobe.
REQ-033 Enter 1,1,3 then press alarm_button -> entry_error; enter 0 then alarm_button -> load_alarm with digits 1,1,3,0.
REQ-034 With KEY_RANGE_CHECK_EN, enter 2,5,0,0 then time_button -> entry_error, no load_time.
REQ-035 Enter 1,2, then 2560 idle cycles -> entry_timeout; all digits and count = 0.
